next_pc_unit: RTL and testbench

Upstream neighbour of the program counter register in the fetch stage. Each cycle it produces the address the PC loads: sequential PC+4, or a redirect from a taken branch, jump, or jump-register. A redirect that resolves while the PC is stalled is latched internally and applied on the first enabled cycle, so no control transfer is lost. It also emits the IF/ID flush request and the PC+4 value consumed by the IF/ID latch.

---
 rtl/next_pc_unit_if.sv | 29 ++
 rtl/next_pc_unit.sv | 76 +++++++
 tb/tb_next_pc_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/next_pc_unit_if.sv
// Fetch-stage next-PC bundle: redirect sources in, PC-register and IF/ID controls out.
interface next_pc_unit_if;
  logic [31:0] pc_current;
  logic        pc_enable;
  logic        br_taken;
  logic [31:0] br_pc_plus4;
  logic [15:0] br_imm;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic        flush_if;
  logic        redirect_pending;
  logic        align_error;

  modport master (
    output pc_current, pc_enable, br_taken, br_pc_plus4, br_imm,
           jump, jump_index, jr, jr_target,
    input  next_pc, pc_plus4, flush_if, redirect_pending, align_error
  );

  modport slave (
    input  pc_current, pc_enable, br_taken, br_pc_plus4, br_imm,
           jump, jump_index, jr, jr_target,
    output next_pc, pc_plus4, flush_if, redirect_pending, align_error
  );
endinterface

// File: rtl/next_pc_unit.sv
// Next-PC selection with a one-entry latch that holds redirects resolved while the PC is stalled.
module next_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] INCREMENT    = 32'd4
) (
  input  logic          clk,
  input  logic          reset,
  next_pc_unit_if.slave bus
);

  typedef enum logic {IDLE, PENDING} state_e;

  state_e      state_q, state_d;
  logic [31:0] pending_target_q, pending_target_d;

  logic        new_redirect;
  logic [31:0] br_target;
  logic [31:0] jump_target;
  logic [31:0] raw_target;
  logic [31:0] new_target;

  // Candidate targets and the jr > jump > branch winner
  always_comb begin
    br_target    = bus.br_pc_plus4 + {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};
    jump_target  = {bus.br_pc_plus4[31:28], bus.jump_index, 2'b00};
    new_redirect = bus.jr | bus.jump | bus.br_taken;
    if (bus.jr)
      raw_target = bus.jr_target;
    else if (bus.jump)
      raw_target = jump_target;
    else
      raw_target = br_target;
    new_target = {raw_target[31:2], 2'b00};
  end

  always_comb begin
    bus.pc_plus4         = bus.pc_current + INCREMENT;
    bus.next_pc          = bus.pc_plus4;
    bus.flush_if         = 1'b0;
    bus.align_error      = 1'b0;
    bus.redirect_pending = (state_q == PENDING);
    if (reset) begin
      bus.next_pc = RESET_VECTOR;
    end else if (new_redirect) begin
      bus.next_pc     = new_target;
      bus.flush_if    = 1'b1;
      bus.align_error = (raw_target[1:0] != 2'b00);
    end else if (state_q == PENDING) begin
      bus.next_pc  = pending_target_q;
      bus.flush_if = 1'b1;
    end
  end

  // A stalled redirect is captured (newest wins); any enabled edge consumes it
  always_comb begin
    state_d          = state_q;
    pending_target_d = pending_target_q;
    if (bus.pc_enable) begin
      state_d = IDLE;
    end else if (new_redirect) begin
      state_d          = PENDING;
      pending_target_d = new_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      pending_target_q <= 32'h0;
    end else begin
      state_q          <= state_d;
      pending_target_q <= pending_target_d;
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: sequential, branch/jump/jr arithmetic, stall latch, reset.
module tb_next_pc_unit;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  next_pc_unit_if bus ();

  next_pc_unit #(.RESET_VECTOR(32'h0000_0100), .INCREMENT(32'd4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_redirects();
    bus.br_taken = 1'b0;
    bus.jump     = 1'b0;
    bus.jr       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.pc_enable = 1'b1;
    bus.pc_current = 32'h0000_0010;
    bus.jr = 1'b1;
    bus.jr_target = 32'h0000_0103;
    @(negedge clk);
    total_cnt++;
    if (bus.next_pc !== 32'h0000_0100) $display("FAIL reset_next_pc got=%h exp=%h", bus.next_pc, 32'h0000_0100);
    else pass_cnt++;
    total_cnt++;
    if (bus.flush_if !== 1'b0) $display("FAIL reset_flush got=%b exp=0", bus.flush_if);
    else pass_cnt++;
    total_cnt++;
    if (bus.align_error !== 1'b0) $display("FAIL reset_align got=%b exp=0", bus.align_error);
    else pass_cnt++;
    total_cnt++;
    if (bus.redirect_pending !== 1'b0) $display("FAIL reset_pending got=%b exp=0", bus.redirect_pending);
    else pass_cnt++;
    clear_redirects();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    @(posedge clk); #1;
    clear_redirects();
    bus.pc_enable  = 1'b1;
    bus.pc_current = 32'h0000_0010;
    @(negedge clk);
    total_cnt++;
    if (bus.next_pc !== 32'h0000_0014) $display("FAIL seq_next_pc got=%h exp=%h", bus.next_pc, 32'h0000_0014);
    else pass_cnt++;
    total_cnt++;
    if (bus.pc_plus4 !== 32'h0000_0014) $display("FAIL seq_pc_plus4 got=%h exp=%h", bus.pc_plus4, 32'h0000_0014);
    else pass_cnt++;
    total_cnt++;
    if (bus.flush_if !== 1'b0) $display("FAIL seq_flush got=%b exp=0", bus.flush_if);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.pc_current = 32'hFFFF_FFFC;
    @(negedge clk);
    total_cnt++;
    if (bus.next_pc !== 32'h0000_0000) $display("FAIL wrap_next_pc got=%h exp=%h", bus.next_pc, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (bus.pc_plus4 !== 32'h0000_0000) $display("FAIL wrap_pc_plus4 got=%h exp=%h", bus.pc_plus4, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    @(posedge clk); #1;
    bus.pc_enable   = 1'b1;
    bus.pc_current  = 32'h0000_003C;
    bus.br_taken    = 1'b1;
    bus.br_pc_plus4 = 32'h0000_0040;
    bus.br_imm      = 16'hFFFE;
    @(negedge clk);
    total_cnt++;
    if (bus.next_pc !== 32'h0000_0038) $display("FAIL br_neg_next_pc got=%h exp=%h", bus.next_pc, 32'h0000_0038);
    else pass_cnt++;
    total_cnt++;
    if (bus.flush_if !== 1'b1) $display("FAIL br_neg_flush got=%b exp=1", bus.flush_if);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.br_imm = 16'h0003;
    @(negedge clk);
    total_cnt++;
    if (bus.next_pc !== 32'h0000_004C) $display("FAIL br_pos_next_pc got=%h exp=%h", bus.next_pc, 32'h0000_004C);
    else pass_cnt++;
    @(posedge clk); #1;
    clear_redirects();
    @(negedge clk);
    total_cnt++;
    if (bus.flush_if !== 1'b0) $display("FAIL br_after_flush got=%b exp=0", bus.flush_if);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    @(posedge clk); #1;
    bus.pc_enable   = 1'b1;
    bus.jr          = 1'b1;
    bus.jump        = 1'b1;
    bus.br_taken    = 1'b1;
    bus.jr_target   = 32'h0000_2000;
    bus.br_pc_plus4 = 32'h0000_0040;
    bus.jump_index  = 26'h0000_123;
    bus.br_imm      = 16'h0001;
    @(negedge clk);
    total_cnt++;
    if (bus.next_pc !== 32'h0000_2000) $display("FAIL prio_jr got=%h exp=%h", bus.next_pc, 32'h0000_2000);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.jr = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.next_pc !== 32'h0000_048C) $display("FAIL prio_jump_over_br got=%h exp=%h", bus.next_pc, 32'h0000_048C);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.br_taken    = 1'b0;
    bus.br_pc_plus4 = 32'hA000_0004;
    bus.jump_index  = 26'h1;
    @(negedge clk);
    total_cnt++;
    if (bus.next_pc !== 32'hA000_0004) $display("FAIL jump_next_pc got=%h exp=%h", bus.next_pc, 32'hA000_0004);
    else pass_cnt++;
    @(posedge clk); #1;
    clear_redirects();
  endtask

  task automatic test_stall_latch();
    @(posedge clk); #1;
    bus.pc_enable   = 1'b0;
    bus.pc_current  = 32'h0000_0200;
    bus.br_taken    = 1'b1;
    bus.br_pc_plus4 = 32'h0000_0040;
    bus.br_imm      = 16'h0010;
    @(negedge clk);
    total_cnt++;
    if (bus.next_pc !== 32'h0000_0080) $display("FAIL stall_new_next_pc got=%h exp=%h", bus.next_pc, 32'h0000_0080);
    else pass_cnt++;
    total_cnt++;
    if (bus.redirect_pending !== 1'b0) $display("FAIL stall_new_pending got=%b exp=0", bus.redirect_pending);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      clear_redirects();
      bus.pc_enable = (i == 3);
      @(negedge clk);
      total_cnt++;
      if (bus.redirect_pending !== 1'b1) $display("FAIL stall_pending_%0d got=%b exp=1", i, bus.redirect_pending);
      else pass_cnt++;
      total_cnt++;
      if (bus.flush_if !== 1'b1) $display("FAIL stall_flush_%0d got=%b exp=1", i, bus.flush_if);
      else pass_cnt++;
      total_cnt++;
      if (bus.next_pc !== 32'h0000_0080) $display("FAIL stall_next_pc_%0d got=%h exp=%h", i, bus.next_pc, 32'h0000_0080);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if (bus.redirect_pending !== 1'b0) $display("FAIL stall_cleared got=%b exp=0", bus.redirect_pending);
    else pass_cnt++;
    total_cnt++;
    if (bus.next_pc !== 32'h0000_0204) $display("FAIL stall_after_next_pc got=%h exp=%h", bus.next_pc, 32'h0000_0204);
    else pass_cnt++;
  endtask

  task automatic test_overwrite();
    @(posedge clk); #1;
    bus.pc_enable   = 1'b0;
    bus.br_taken    = 1'b1;
    bus.br_pc_plus4 = 32'h0000_0040;
    bus.br_imm      = 16'h0010;
    @(posedge clk); #1;
    bus.br_taken  = 1'b0;
    bus.jr        = 1'b1;
    bus.jr_target = 32'h0000_0100;
    @(negedge clk);
    total_cnt++;
    if (bus.next_pc !== 32'h0000_0100) $display("FAIL ovw_new_wins got=%h exp=%h", bus.next_pc, 32'h0000_0100);
    else pass_cnt++;
    @(posedge clk); #1;
    clear_redirects();
    bus.pc_enable = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (bus.next_pc !== 32'h0000_0100) $display("FAIL ovw_applied got=%h exp=%h", bus.next_pc, 32'h0000_0100);
    else pass_cnt++;
    total_cnt++;
    if (bus.flush_if !== 1'b1) $display("FAIL ovw_flush got=%b exp=1", bus.flush_if);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    @(posedge clk); #1;
    bus.pc_enable   = 1'b0;
    bus.br_taken    = 1'b1;
    bus.br_pc_plus4 = 32'h0000_0040;
    bus.br_imm      = 16'h0010;
    @(posedge clk); #1;
    clear_redirects();
    @(negedge clk);
    total_cnt++;
    if (bus.redirect_pending !== 1'b1) $display("FAIL rstmid_pre_pending got=%b exp=1", bus.redirect_pending);
    else pass_cnt++;
    #1 reset = 1'b1;
    #1;
    total_cnt++;
    if (bus.redirect_pending !== 1'b0) $display("FAIL rstmid_pending_drop got=%b exp=0", bus.redirect_pending);
    else pass_cnt++;
    total_cnt++;
    if (bus.next_pc !== 32'h0000_0100) $display("FAIL rstmid_next_pc got=%h exp=%h", bus.next_pc, 32'h0000_0100);
    else pass_cnt++;
    #1 reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if (bus.flush_if !== 1'b0) $display("FAIL rstmid_no_flush got=%b exp=0", bus.flush_if);
    else pass_cnt++;
    total_cnt++;
    if (bus.redirect_pending !== 1'b0) $display("FAIL rstmid_pending_after got=%b exp=0", bus.redirect_pending);
    else pass_cnt++;
  endtask

  task automatic test_misalign();
    @(posedge clk); #1;
    bus.pc_enable = 1'b1;
    bus.jr        = 1'b1;
    bus.jr_target = 32'h0000_0103;
    @(negedge clk);
    total_cnt++;
    if (bus.next_pc !== 32'h0000_0100) $display("FAIL mis_next_pc got=%h exp=%h", bus.next_pc, 32'h0000_0100);
    else pass_cnt++;
    total_cnt++;
    if (bus.align_error !== 1'b1) $display("FAIL mis_align got=%b exp=1", bus.align_error);
    else pass_cnt++;
    @(posedge clk); #1;
    clear_redirects();
    @(negedge clk);
    total_cnt++;
    if (bus.align_error !== 1'b0) $display("FAIL mis_align_pulse got=%b exp=0", bus.align_error);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.pc_enable = 1'b0;
    bus.jr        = 1'b1;
    bus.jr_target = 32'h0000_0302;
    @(negedge clk);
    total_cnt++;
    if (bus.align_error !== 1'b1) $display("FAIL mis_stall_align got=%b exp=1", bus.align_error);
    else pass_cnt++;
    @(posedge clk); #1;
    clear_redirects();
    @(negedge clk);
    total_cnt++;
    if (bus.align_error !== 1'b0) $display("FAIL mis_stall_pulse got=%b exp=0", bus.align_error);
    else pass_cnt++;
    total_cnt++;
    if (bus.next_pc !== 32'h0000_0300) $display("FAIL mis_stall_target got=%h exp=%h", bus.next_pc, 32'h0000_0300);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.pc_enable = 1'b1;
  endtask

  initial begin
    pass_cnt        = 0;
    total_cnt       = 0;
    reset           = 1'b1;
    bus.pc_current  = 32'h0;
    bus.pc_enable   = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_pc_plus4 = 32'h0;
    bus.br_imm      = 16'h0;
    bus.jump        = 1'b0;
    bus.jump_index  = 26'h0;
    bus.jr          = 1'b0;
    bus.jr_target   = 32'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_priority();
    test_stall_latch();
    test_overwrite();
    test_reset_mid_stall();
    test_misalign();
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
